csa_accum_ctrl: RTL and testbench
=================================

Name: csa_accum_ctrl

Overview:
Sequencer that time-shares one WIDTH-bit 3:2 carry-save adder stage to accumulate a variable-length stream of operands, one per cycle, in redundant (sum, carry) form. After the last operand it resolves the redundant pair with a chunked carry-propagate add over WIDTH/CHUNK cycles and presents the result modulo 2^WIDTH. It sits between the partial-product generator and the final-adder/reduction stage of the 40x40 multiplier datapath.

Parameters:
WIDTH, 44, operand/accumulator width in bits
CHUNK, 11, bits resolved per cycle in the final add; WIDTH must be a multiple of CHUNK
CNT_W, 8, width of the operand counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  operand accepted when in_valid & in_ready
in_data  input  WIDTH  operand
in_last  input  1  marks the final operand of a group
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid & out_ready
out_data  output  WIDTH  sum of the group's operands mod 2^WIDTH
out_count  output  CNT_W  operands in the group, saturating
out_sat  output  1  count saturated at 2^CNT_W-1

Behaviour:
- Reset, asynchronous, rst_n=0: state=IDLE; S, C, out_data, out_count, carry register = 0; out_valid=0, out_sat=0, in_ready=0 while rst_n=0.
- Datapath is one 3:2 CSA step per accepted beat.
  - s_i = x_i^y_i^z_i.
  - c_{i+1} = maj(x_i, y_i, z_i); c_0 = 0.
  - The carry out of bit WIDTH-1 is discarded, so the arithmetic is mod 2^WIDTH.
- Invariant: (S + C) mod 2^WIDTH equals the running sum.
- State IDLE, in_ready=1.
  - On accept: S<=in_data, C<=0, cnt<=1, sat<=0.
  - Next state is RESOLVE if in_last, else ACCUM.
- State ACCUM, in_ready=1.
  - On accept: (C,S)<=CSA(S, C, in_data).
  - cnt increments and saturates at all-ones; sat is set when an increment is attempted at all-ones.
  - in_last moves to RESOLVE.
  - With no valid input, all registers are held and there is no timeout.
- State RESOLVE, in_ready=0, lasts WIDTH/CHUNK cycles (4 by default).
  - Chunk k (k = 0 upward) computes {cy, out_data[k*CHUNK+:CHUNK]} = S_chunk + C_chunk + cy, with cy=0 at k=0.
  - The final chunk carry is dropped.
  - After the last chunk: state=DONE, out_valid=1, out_count=cnt, out_sat=sat.
- State DONE, in_ready=0.
  - out_valid, out_data, out_count and out_sat are held stable until out_ready.
  - On handshake: out_valid<=0, state=IDLE.
  - No new operand is accepted in the handshake cycle; in_ready rises the next cycle.
- Latency: the last operand is accepted at edge t, and out_valid is 1 after edge t+WIDTH/CHUNK.
- Throughput: a group of N operands occupies N + WIDTH/CHUNK + 1 cycles at minimum (with out_ready=1).
- in_valid & in_last on the first beat is a single-operand group: result = operand, count = 1.
- in_last is ignored when in_valid=0.
- rst_n asserted in any state aborts the group with no output.
- Inputs sampled while in_ready=0 have no effect.

Test Plan:
- Operands 1, 2, 3 (last on 3), out_ready=1 -> out_valid 4 cycles after the last accept; out_data=6, out_count=3, out_sat=0.
- Single operand 0x0ABCDEF0123 with in_last -> out_data=0x0ABCDEF0123, out_count=1.
- Operands 0xFFFFFFFFFFF and 0x00000000001 -> out_data=0, confirming the wrap and that the chunk carry ripples across all 4 chunks.
- Result ready with out_ready=0 for 5 cycles -> out_valid, out_data and out_count stable; in_ready=0; a single out_ready pulse -> out_valid=0 the next cycle, in_ready=1 one cycle later.
- 300 operands of value 1 -> out_data=300 (0x12C), out_count=255, out_sat=1.
- rst_n low for one cycle mid-ACCUM after 2 operands, then a group of 5 and 7 -> out_data=12, out_count=2, with no stale contribution and no result from the aborted group.

Source files
------------

// File: rtl/csa_accum_ctrl.sv
// Carry-save accumulator sequencer: accumulates a stream of operands in redundant
// (sum, carry) form, then resolves the pair with a chunked carry-propagate add.
`timescale 1ns/1ps
module csa_accum_ctrl #(
    parameter int unsigned WIDTH = 44,
    parameter int unsigned CHUNK = 11,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     s_q;
    logic [WIDTH-1:0]     c_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sat_q;
    logic [KW-1:0]        k_q;
    logic                 cy_q;

    logic                 accept;
    logic [WIDTH-1:0]     csa_s;
    logic [WIDTH-1:0]     csa_c;
    logic [CHUNK:0]       chunk_sum;
    logic [WIDTH+CHUNK-1:0] od_shift;

    // 3:2 compression; the carry out of the top bit falls off the shift
    always_comb begin
        accept    = in_valid & in_ready;
        csa_s     = s_q ^ c_q ^ in_data;
        csa_c     = ((s_q & c_q) | (s_q & in_data) | (c_q & in_data)) << 1;
        chunk_sum = (CHUNK+1)'(s_q[CHUNK-1:0]) + (CHUNK+1)'(c_q[CHUNK-1:0])
                  + (CHUNK+1)'(cy_q);
        od_shift  = {chunk_sum[CHUNK-1:0], out_data} >> CHUNK;
    end

    // S and C shift down one chunk per resolve cycle; result fills from the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_q       <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            k_q       <= '0;
            cy_q      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        s_q   <= in_data;
                        c_q   <= '0;
                        cnt_q <= CNT_W'(1);
                        sat_q <= 1'b0;
                        if (in_last) begin
                            state    <= RESOLVE;
                            in_ready <= 1'b0;
                            k_q      <= '0;
                            cy_q     <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        s_q <= csa_s;
                        c_q <= csa_c;
                        if (&cnt_q) begin
                            sat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (in_last) begin
                            state    <= RESOLVE;
                            in_ready <= 1'b0;
                            k_q      <= '0;
                            cy_q     <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    in_ready <= 1'b0;
                    s_q      <= s_q >> CHUNK;
                    c_q      <= c_q >> CHUNK;
                    cy_q     <= chunk_sum[CHUNK];
                    out_data <= od_shift[WIDTH-1:0];
                    k_q      <= k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_count <= cnt_q;
                        out_sat   <= sat_q;
                    end
                end
                DONE: begin
                    in_ready <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Bench for csa_accum_ctrl: directed vector table, saturation/abort sequences and
// randomized groups checked against a plain-arithmetic sum/count model.
`timescale 1ns/1ps
module tb_csa_accum_ctrl;

    localparam int unsigned W  = 44;
    localparam int unsigned CW = 8;
    localparam int unsigned LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_sat;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] gq[$];

    typedef struct packed {
        logic [2:0]         n;
        logic [3:0][W-1:0]  op;
        logic [W-1:0]       ed;
        logic [CW-1:0]      ec;
        logic               es;
        logic [2:0]         hold;
    } vec_t;

    vec_t tbl[7];

    csa_accum_ctrl #(.WIDTH(44), .CHUNK(11), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs(input bit allow_valid);
        in_valid = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = {12'($urandom), 32'($urandom)};
    endtask

    task automatic wait_ready;
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    function automatic vec_t mk(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] d,
                                input logic [W-1:0] ed, input int ec, input bit es,
                                input int hold);
        vec_t v;
        v.n     = 3'(n);
        v.op[0] = a;
        v.op[1] = b;
        v.op[2] = c;
        v.op[3] = d;
        v.ed    = ed;
        v.ec    = CW'(ec);
        v.es    = es;
        v.hold  = 3'(hold);
        return v;
    endfunction

    // Drives the operands in gq as one group, then checks latency, hold and result
    task automatic run_group(input string nm, input int gapmax, input int hold,
                             input logic [W-1:0] ed, input logic [CW-1:0] ec, input logic es);
        logic [W-1:0]  d0;
        logic [CW-1:0] c0;
        int lat;
        for (int i = 0; i < gq.size(); i++) begin
            wait_ready();
            repeat ($urandom_range(0, gapmax)) begin
                junk_inputs(0);
                tick();
            end
            in_valid = 1'b1;
            in_data  = gq[i];
            in_last  = (i == gq.size() - 1);
            tick();
        end
        junk_inputs(1);
        chk({nm, "_ready_low"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            junk_inputs(1);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(LAT));
        d0 = out_data;
        c0 = out_count;
        for (int h = 0; h < hold; h++) begin
            tick();
            junk_inputs(1);
            chk({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({nm, "_hold_data"}, 64'(out_data), 64'(d0));
            chk({nm, "_hold_count"}, 64'(out_count), 64'(c0));
            chk({nm, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        chk({nm, "_data"}, 64'(out_data), 64'(ed));
        chk({nm, "_count"}, 64'(out_count), 64'(ec));
        chk({nm, "_sat"}, 64'(out_sat), 64'(es));
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        chk({nm, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({nm, "_ready_rise"}, 64'(in_ready), 64'd1);
    endtask

    task automatic fill_const(input int n, input logic [W-1:0] v);
        gq.delete();
        for (int i = 0; i < n; i++) gq.push_back(v);
    endtask

    initial begin
        logic [W-1:0] ref_sum;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        tbl[0] = mk(3, 44'd1, 44'd2, 44'd3, 44'd0, 44'd6, 3, 1'b0, 0);
        tbl[1] = mk(1, 44'h0ABCDEF0123, 44'd0, 44'd0, 44'd0, 44'h0ABCDEF0123, 1, 1'b0, 0);
        tbl[2] = mk(2, 44'hFFFFFFFFFFF, 44'h00000000001, 44'd0, 44'd0, 44'd0, 2, 1'b0, 0);
        tbl[3] = mk(2, 44'h123, 44'h456, 44'd0, 44'd0, 44'h579, 2, 1'b0, 5);
        tbl[4] = mk(2, 44'h7FF, 44'h001, 44'd0, 44'd0, 44'h800, 2, 1'b0, 1);
        tbl[5] = mk(4, 44'h80000000000, 44'h80000000000, 44'h00100000000, 44'h3,
                    44'h00100000003, 4, 1'b0, 2);
        tbl[6] = mk(3, 44'hFFFFFFFFFFF, 44'hFFFFFFFFFFF, 44'hFFFFFFFFFFF, 44'd0,
                    44'hFFFFFFFFFFD, 3, 1'b0, 0);

        repeat (2) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            gq.delete();
            for (int j = 0; j < int'(tbl[i].n); j++) gq.push_back(tbl[i].op[j]);
            run_group($sformatf("vec%0d", i), 0, int'(tbl[i].hold),
                      tbl[i].ed, tbl[i].ec, tbl[i].es);
        end

        fill_const(255, 44'd1);
        run_group("cnt255", 0, 0, 44'd255, 8'd255, 1'b0);
        fill_const(256, 44'd1);
        run_group("cnt256", 0, 0, 44'd256, 8'd255, 1'b1);
        fill_const(300, 44'd1);
        run_group("cnt300", 1, 0, 44'h12C, 8'd255, 1'b1);

        // abort a partially accumulated group with reset
        wait_ready();
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 44'h111;
        tick();
        in_data  = 44'h222;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_out_count", 64'(out_count), 64'd0);
        chk("abort_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        gq.delete();
        gq.push_back(44'd5);
        gq.push_back(44'd7);
        run_group("after_abort", 0, 0, 44'd12, 8'd2, 1'b0);

        for (int g = 0; g < 40; g++) begin
            n = int'($urandom_range(1, 12));
            gq.delete();
            ref_sum = '0;
            for (int j = 0; j < n; j++) begin
                logic [W-1:0] v;
                v = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : {12'($urandom), 32'($urandom)};
                gq.push_back(v);
                ref_sum = ref_sum + v;
            end
            run_group($sformatf("rand%0d", g), 2, int'($urandom_range(0, 3)),
                      ref_sum, CW'(n), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
